dma_handshake_monitor: RTL
==========================

# dma_handshake_monitor

Synthesizable, parametrised bus-handshake monitor for the DMA controller. It passively observes DREQ/HRQ/HLDA/DACK/EOP_N for NUM_CH channels and tracks each service cycle with its own FSM. Against an internal fixed/rotating priority model it flags protocol and priority violations as sticky error bits and counts grants per channel. It sits beside the DMA controller on the same bus interface and drives nothing on the bus; its outputs go to a debug/status register bank and to formal and simulation benches.

## Interface
- NUM_CH, 4: number of DMA channels (2..16).
- TIMEOUT, 16: maximum cycles HRQ may stay high without HLDA (≥2).
- CNT_W, 16: width of each per-channel grant counter.
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  NUM_CH  channel requests, active-high.
- DACK  in  NUM_CH  channel acknowledges, active-high.
- HRQ  in  1  hold request from the DMA controller.
- HLDA  in  1  hold acknowledge from the CPU.
- EOP_N  in  1  end of process, active-low.
- rotatePriority  in  1  0 = fixed priority (channel 0 highest), 1 = rotating.
- errClear  in  1  clears all sticky error bits.
- errFlags  out  5  sticky errors: [0] DACK not one-hot, [1] DACK while HLDA low, [2] priority violation, [3] HRQ timeout, [4] DACK to a channel with no prior DREQ.
- grantCount  out  NUM_CH*CNT_W  per-channel grant counts; channel i at bits [i*CNT_W +: CNT_W].
- monState  out  2  current FSM state.
- expectedDACK  out  NUM_CH  one-hot grant predicted by the priority model; all zeros if DREQ is zero.
- maxLatency  out  16  longest HRQ-rise-to-first-DACK latency (see Configuration).

## Operation
- FSM states: MON_IDLE=0, MON_REQ=1, MON_HOLD=2, MON_XFER=3.
- MON_IDLE: HRQ&HLDA → MON_HOLD; HRQ alone → MON_REQ.
- MON_REQ: HLDA → MON_HOLD; !HRQ → MON_IDLE; otherwise increment the timeout counter. When the counter reaches TIMEOUT−1, set err[3] and hold the counter there; the FSM stays in MON_REQ.
- MON_HOLD: |DACK → MON_XFER; !HRQ or !HLDA → MON_IDLE.
- MON_XFER: DACK==0 or !EOP_N → MON_IDLE. On exit, the serviced channel k is recorded. If rotatePriority=1, channel k becomes lowest priority, so (k+1) mod NUM_CH becomes highest.
- On MON_HOLD→MON_XFER:
  - Compare DACK with expectedDACK registered in the previous cycle. A mismatch sets err[2].
  - If the registered DREQ bit for the granted channel is 0, set err[4].
  - grantCount[k] increments, saturating at all-ones.
- Checked in every state:
  - DACK non-zero and not one-hot → err[0].
  - DACK non-zero while HLDA=0 → err[1].
- Error bits are sticky until errClear. If a set and errClear occur in the same cycle, set wins.
- The priority pointer resets to NUM_CH−1, giving channel 0 highest priority. Changing rotatePriority mid-transfer takes effect at the next MON_HOLD cycle.

## Timing
- Reset values:
  - monState=MON_IDLE
  - errFlags=0
  - grantCount=0
  - maxLatency=0
  - expectedDACK=0
  - priority pointer=NUM_CH−1
  - timeout counter=0
- Error bits rise one cycle after the offending sample (registered).
- expectedDACK is registered: it reflects DREQ and the pointer from the previous cycle.
- RESET asserted mid-transfer: next cycle equals the reset state; no error is flagged for the interrupted transfer.
- The DACK compare uses the registered expectation from cycle t−1 against DACK at cycle t.
- Timeout counter width is $clog2(TIMEOUT+1). It clears on entry to MON_REQ.

## Configuration
- DMA_MON_LATENCY_EN defined:
  - A 16-bit counter starts on the HRQ rising edge and stops on the first DACK.
  - maxLatency holds the running maximum and saturates at 16'hFFFF.
  - errClear also clears maxLatency.
- Not defined: maxLatency is tied to 0, no counter is synthesized, and the port still exists.

## Structure
- Package dma_mon_pkg contains:
  - the monState_t enum;
  - localparams for the errFlags bit indices (ERR_ONEHOT, ERR_NOHLDA, ERR_PRIO, ERR_TIMEOUT, ERR_NODREQ);
  - a DMA_MON_ERR_W=5 constant.
- Sub-module dma_prio_model is combinational: it takes DREQ, the pointer and rotatePriority, and produces a one-hot grant plus the grant index.
- The top level holds the FSM, counters, the registered expectation and the sticky errors.

## Test plan
- Fixed priority: DREQ=4'b0110, HRQ, HLDA, then DACK=4'b0010 → errFlags=0, grantCount[1]=1, monState returns to 0 after DACK drops.
- Fixed priority violation: DREQ=4'b0011, DACK=4'b0010 → err[2] set the next cycle, sticky until errClear.
- Rotating priority: service channel 0, then DREQ=4'b1111 → expectedDACK=4'b0010; DACK=4'b0010 passes, DACK=4'b0001 sets err[2].
- Timeout: HRQ=1, HLDA=0 for TIMEOUT=16 cycles → err[3] rises after cycle 16; HLDA then → MON_HOLD.
- Protocol errors: DACK=4'b0011 with HLDA=1 → err[0]; DACK=4'b0001 with HLDA=0 → err[1]; errClear together with a new violation → the bit stays set.
- Reset mid-MON_XFER → all outputs zero and monState=0 on the next cycle; with DMA_MON_LATENCY_EN, HRQ→DACK after 5 cycles gives maxLatency=5.

Source files
------------

// File: rtl/dma_handshake_monitor_pkg.sv
// Shared types and constants for the DMA handshake monitor.
//   monState_t    : monitor FSM state encoding (also exported on monState)
//   DMA_MON_ERR_W : width of the sticky error vector
//   ERR_*         : bit positions inside errFlags
package dma_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_REQ  = 2'd1,
        MON_HOLD = 2'd2,
        MON_XFER = 2'd3
    } monState_t;

    localparam int DMA_MON_ERR_W = 5;

    localparam int ERR_ONEHOT  = 0;  // DACK has more than one bit set
    localparam int ERR_NOHLDA  = 1;  // DACK asserted while HLDA is low
    localparam int ERR_PRIO    = 2;  // granted channel differs from the priority model
    localparam int ERR_TIMEOUT = 3;  // HRQ held too long without HLDA
    localparam int ERR_NODREQ  = 4;  // DACK to a channel that was not requesting

endpackage

// File: rtl/dma_handshake_monitor_if.sv
// Bus bundle observed by the DMA handshake monitor.
//   DREQ/DACK : per-channel request / acknowledge, active-high
//   HRQ/HLDA  : hold request / hold acknowledge
//   EOP_N     : end of process, active-low
// Modports:
//   master : the side that drives the bus (controller/CPU model)
//   slave  : a passive observer; every signal is an input
interface dma_handshake_monitor_if #(
    parameter int NUM_CH = 4
);

    logic [NUM_CH-1:0] DREQ;
    logic [NUM_CH-1:0] DACK;
    logic              HRQ;
    logic              HLDA;
    logic              EOP_N;

    modport master (output DREQ, output DACK, output HRQ, output HLDA, output EOP_N);
    modport slave  (input  DREQ, input  DACK, input  HRQ, input  HLDA, input  EOP_N);

endinterface

// File: rtl/dma_handshake_monitor_prio_model.sv
// Combinational DMA priority model.
//   dreq      : channel requests
//   ptr       : channel that was serviced last (lowest priority when rotating)
//   rotate    : 0 = fixed (channel 0 highest), 1 = rotating from ptr+1
//   grant     : one-hot winner, all zeros when dreq is zero
//   grant_idx : index of the winner (0 when nothing is requested)
module dma_prio_model #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_CH-1:0] dreq,
    input  logic [PTR_W-1:0]  ptr,
    input  logic              rotate,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  grant_idx
);

    logic [PTR_W-1:0] start;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        start     = '0;
        if (rotate && (ptr != PTR_W'(NUM_CH - 1))) begin
            start = ptr + 1'b1;
        end
        // Scan channels starting at the highest-priority one, wrapping round.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = PTR_W'((32'(start) + i) % NUM_CH);
            if (!found && dreq[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                grant_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/dma_handshake_monitor.sv
// Passive DMA bus-handshake monitor.
// Watches DREQ/DACK/HRQ/HLDA/EOP_N, tracks each service cycle with an FSM,
// compares grants against a fixed/rotating priority model, keeps sticky
// protocol error flags and per-channel saturating grant counters.
// Ports:
//   CLK, RESET     : clock, synchronous active-high reset
//   bus            : observed handshake signals (slave modport)
//   rotatePriority : 0 = fixed priority, 1 = rotating priority
//   errClear       : clears sticky errors (a new error in the same cycle wins)
//   errFlags       : sticky errors, see ERR_* in dma_mon_pkg
//   grantCount     : per-channel grant counters, channel i at [i*CNT_W +: CNT_W]
//   monState       : current FSM state
//   expectedDACK   : registered one-hot grant predicted by the priority model
//   maxLatency     : longest HRQ-rise to first-DACK latency
// Build option: define DMA_MON_LATENCY_EN to enable the latency tracker;
// otherwise maxLatency is tied to zero.
module dma_handshake_monitor
    import dma_mon_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    dma_handshake_monitor_if.slave   bus,
    input  logic                     rotatePriority,
    input  logic                     errClear,
    output logic [DMA_MON_ERR_W-1:0] errFlags,
    output logic [NUM_CH*CNT_W-1:0]  grantCount,
    output logic [1:0]               monState,
    output logic [NUM_CH-1:0]        expectedDACK,
    output logic [15:0]              maxLatency
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_CH - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ARM  = TO_W'(TIMEOUT - 2);

    monState_t               state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        svc_ch_q, svc_ch_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [DMA_MON_ERR_W-1:0] err_q, err_d, err_set;
    logic [NUM_CH-1:0]       exp_dack_q, exp_dack_d;
    logic [NUM_CH-1:0]       dreq_q, dreq_d;
    logic [CNT_W-1:0]        grant_q [NUM_CH];
    logic [CNT_W-1:0]        grant_d [NUM_CH];

    logic [NUM_CH-1:0]       pred_grant;
    logic [PTR_W-1:0]        pred_idx_unused;  // expectation is compared as a one-hot vector
    logic [NUM_CH-1:0]       dack_lsb;
    logic [PTR_W-1:0]        dack_idx;
    logic                    dack_any;

    dma_prio_model #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_prio (
        .dreq      (bus.DREQ),
        .ptr       (ptr_q),
        .rotate    (rotatePriority),
        .grant     (pred_grant),
        .grant_idx (pred_idx_unused)
    );

    // Same model in fixed mode acts as a lowest-set-bit encoder for DACK:
    // DACK is one-hot exactly when it equals its lowest set bit.
    dma_prio_model #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_dack_enc (
        .dreq      (bus.DACK),
        .ptr       (PTR_RST),
        .rotate    (1'b0),
        .grant     (dack_lsb),
        .grant_idx (dack_idx)
    );

    assign dack_any = |bus.DACK;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        svc_ch_d   = svc_ch_q;
        to_cnt_d   = to_cnt_q;
        grant_d    = grant_q;
        err_set    = '0;
        dreq_d     = bus.DREQ;
        exp_dack_d = pred_grant;

        if (dack_any && (bus.DACK != dack_lsb)) err_set[ERR_ONEHOT] = 1'b1;
        if (dack_any && !bus.HLDA)              err_set[ERR_NOHLDA] = 1'b1;

        case (state_q)
            MON_IDLE: begin
                if (bus.HRQ && bus.HLDA) begin
                    state_d = MON_HOLD;
                end else if (bus.HRQ) begin
                    state_d  = MON_REQ;
                    to_cnt_d = '0;
                end
            end
            MON_REQ: begin
                if (bus.HLDA) begin
                    state_d = MON_HOLD;
                end else if (!bus.HRQ) begin
                    state_d = MON_IDLE;
                end else begin
                    // Flag on the cycle the counter reaches TIMEOUT-1, then hold it there.
                    if (to_cnt_q >= TO_ARM)  err_set[ERR_TIMEOUT] = 1'b1;
                    if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            MON_HOLD: begin
                if (dack_any) begin
                    state_d  = MON_XFER;
                    svc_ch_d = dack_idx;
                    if (bus.DACK != exp_dack_q)  err_set[ERR_PRIO]   = 1'b1;
                    if (!dreq_q[dack_idx])       err_set[ERR_NODREQ] = 1'b1;
                    if (grant_q[dack_idx] != '1) grant_d[dack_idx] = grant_q[dack_idx] + 1'b1;
                end else if (!bus.HRQ || !bus.HLDA) begin
                    state_d = MON_IDLE;
                end
            end
            MON_XFER: begin
                if (!dack_any || !bus.EOP_N) begin
                    state_d = MON_IDLE;
                    if (rotatePriority) ptr_d = svc_ch_q;
                end
            end
            default: state_d = MON_IDLE;
        endcase

        err_d = errClear ? err_set : (err_q | err_set);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= MON_IDLE;
            ptr_q      <= PTR_RST;
            svc_ch_q   <= '0;
            to_cnt_q   <= '0;
            err_q      <= '0;
            exp_dack_q <= '0;
            dreq_q     <= '0;
            grant_q    <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            svc_ch_q   <= svc_ch_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
            exp_dack_q <= exp_dack_d;
            dreq_q     <= dreq_d;
            grant_q    <= grant_d;
        end
    end

    always_comb begin
        grantCount = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            grantCount[i*CNT_W +: CNT_W] = grant_q[i];
        end
    end

    assign errFlags     = err_q;
    assign monState     = state_q;
    assign expectedDACK = exp_dack_q;

`ifdef DMA_MON_LATENCY_EN
    logic        hrq_q, hrq_d;
    logic        lat_run_q, lat_run_d;
    logic [15:0] lat_cnt_q, lat_cnt_d;
    logic [15:0] max_lat_q, max_lat_d;

    always_comb begin
        hrq_d     = bus.HRQ;
        lat_run_d = lat_run_q;
        lat_cnt_d = lat_cnt_q;
        max_lat_d = errClear ? '0 : max_lat_q;
        if (bus.HRQ && !hrq_q) begin
            // Rise cycle counts as 1, so a DACK N cycles later reports N.
            lat_run_d = 1'b1;
            lat_cnt_d = 16'd1;
        end else if (lat_run_q) begin
            if (dack_any) begin
                lat_run_d = 1'b0;
                if (errClear || (lat_cnt_q > max_lat_q)) max_lat_d = lat_cnt_q;
            end else if (lat_cnt_q != '1) begin
                lat_cnt_d = lat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hrq_q     <= 1'b0;
            lat_run_q <= 1'b0;
            lat_cnt_q <= '0;
            max_lat_q <= '0;
        end else begin
            hrq_q     <= hrq_d;
            lat_run_q <= lat_run_d;
            lat_cnt_q <= lat_cnt_d;
            max_lat_q <= max_lat_d;
        end
    end

    assign maxLatency = max_lat_q;
`else
    assign maxLatency = '0;
`endif

endmodule
